dmem_mmio_responder: RTL and testbench

- Responder for the single-cycle core's data-memory port: `MemWrite`, `ALUResult` (address), `WriteData` in; `ReadData` out.
- Provides a word-addressed data RAM plus a small MMIO region: a free-running cycle timer and a byte TX FIFO drained over a valid/ready handshake.
- Reads are combinational so the single-cycle core completes loads in one cycle. All state updates on the rising clock edge.

---
 rtl/dmem_mmio_responder_if.sv | 21 ++
 rtl/dmem_mmio_responder.sv | 100 ++++++++++
 tb/tb_dmem_mmio_responder.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_mmio_responder_if.sv
// Data-memory port of the single-cycle core plus the TX byte stream handshake.
interface dmem_mmio_responder_if;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        err;

  modport slave (
    input  MemWrite, ALUResult, WriteData, tx_ready,
    output ReadData, tx_data, tx_valid, err
  );

  modport master (
    output MemWrite, ALUResult, WriteData, tx_ready,
    input  ReadData, tx_data, tx_valid, err
  );
endinterface

// File: rtl/dmem_mmio_responder.sv
// Word-addressed data RAM plus MMIO timer, TX byte FIFO and sticky error flags.
// Loads are combinational so the core finishes them in the same cycle.
module dmem_mmio_responder #(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
  input logic                  clk,
  input logic                  reset,
  dmem_mmio_responder_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   r_mem  [DEPTH];
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_timer;
  logic          r_ovf;
  logic          r_err;

  logic [29:0]   w_word_off;
  logic [AW-1:0] w_idx;
  logic          w_ram_hit;
  logic          w_tmr_hit;
  logic          w_tx_hit;
  logic          w_ctrl_hit;
  logic          w_unmapped;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_ovf_set;
  logic          w_err_set;
  logic          w_ctrl_we;
  logic [31:0]   w_status;

  // Address bits [1:0] are ignored everywhere; MMIO decode works on word offsets.
  assign w_ram_hit  = bus.ALUResult < 32'(DEPTH * 4);
  assign w_idx      = bus.ALUResult[AW+1:2];
  assign w_word_off = bus.ALUResult[31:2] - MMIO_BASE[31:2];
  assign w_tmr_hit  = !w_ram_hit && (w_word_off == 30'd0);
  assign w_tx_hit   = !w_ram_hit && (w_word_off == 30'd1);
  assign w_ctrl_hit = !w_ram_hit && (w_word_off == 30'd2);
  assign w_unmapped = !(w_ram_hit || w_tmr_hit || w_tx_hit || w_ctrl_hit);

  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_push    = bus.MemWrite && w_tx_hit && !w_full;
  assign w_pop     = !w_empty && bus.tx_ready;
  assign w_ovf_set = bus.MemWrite && w_tx_hit && w_full;
  assign w_err_set = bus.MemWrite && w_unmapped;
  assign w_ctrl_we = bus.MemWrite && w_ctrl_hit;
  assign w_status  = {20'd0, r_err, r_ovf, w_empty, w_full, 8'(r_count)};

  always_comb begin
    bus.ReadData = '0;
    if (w_ram_hit)      bus.ReadData = r_mem[w_idx];
    else if (w_tmr_hit) bus.ReadData = r_timer;
    else if (w_tx_hit)  bus.ReadData = w_status;
  end

  assign bus.tx_data  = r_fifo[r_rd_ptr];
  assign bus.tx_valid = !w_empty;
  assign bus.err      = r_err;

  // Storage arrays carry no reset; only the bookkeeping around them does.
  always_ff @(posedge clk) begin
    if (bus.MemWrite && w_ram_hit) r_mem[w_idx] <= bus.WriteData;
    if (w_push)                    r_fifo[r_wr_ptr] <= bus.WriteData[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (bus.MemWrite && w_tmr_hit) r_timer <= bus.WriteData;
      else                           r_timer <= r_timer + 32'd1;

      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);

      // A new event in the same cycle outranks a CTRL clear.
      if (w_ovf_set)                          r_ovf <= 1'b1;
      else if (w_ctrl_we && bus.WriteData[0]) r_ovf <= 1'b0;
      if (w_err_set)                          r_err <= 1'b1;
      else if (w_ctrl_we && bus.WriteData[1]) r_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder against a queue-based behavioural model.
module tb_dmem_mmio_responder;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] TMR  = BASE;
  localparam logic [31:0] TXA  = BASE + 32'd4;
  localparam logic [31:0] CTL  = BASE + 32'd8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_mmio_responder_if bus ();
  dmem_mmio_responder #(.DEPTH(64), .FIFO_DEPTH(4), .MMIO_BASE(BASE)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_ram [64];
  bit          m_wr  [64];
  logic [31:0] m_timer;
  logic [7:0]  m_q [$];
  bit          m_ovf;
  bit          m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] off;
    if (a < 32'd256) return m_ram[a[7:2]];
    off = a - BASE;
    case (off[31:2])
      30'd0:   return m_timer;
      30'd1:   return {20'd0, m_err, m_ovf, m_q.size() == 0, m_q.size() == 4, 8'(m_q.size())};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_timer = 32'd0;
    m_q.delete();
    m_ovf = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] a, d, off;
    bit we, pop, full, push, tw;
    if (reset) begin
      model_reset();
      return;
    end
    a = bus.ALUResult; d = bus.WriteData; we = bus.MemWrite;
    off = a - BASE;
    pop = (m_q.size() != 0) && bus.tx_ready;
    full = (m_q.size() == 4);
    push = 1'b0; tw = 1'b0;
    if (we) begin
      if (a < 32'd256) begin
        m_ram[a[7:2]] = d;
        m_wr[a[7:2]] = 1'b1;
      end else if (off[31:2] == 30'd0) begin
        tw = 1'b1;
      end else if (off[31:2] == 30'd1) begin
        if (full) m_ovf = 1'b1;
        else push = 1'b1;
      end else if (off[31:2] == 30'd2) begin
        if (d[0]) m_ovf = 1'b0;
        if (d[1]) m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
    m_timer = tw ? d : m_timer + 32'd1;
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(d[7:0]);
  endtask

  task automatic compare_all();
    logic [31:0] a;
    a = bus.ALUResult;
    if (!(a < 32'd256 && !m_wr[a[7:2]])) check("ReadData", bus.ReadData, m_read(a));
    check("tx_valid", 32'(bus.tx_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) check("tx_data", 32'(bus.tx_data), 32'(m_q[0]));
    check("err", 32'(bus.err), 32'(m_err));
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input bit we, input logic [31:0] a, input logic [31:0] d);
    bus.MemWrite = we;
    bus.ALUResult = a;
    bus.WriteData = d;
  endtask

  task automatic look(input logic [31:0] a, input logic [31:0] exp, input string name);
    drive(1'b0, a, 32'd0);
    #1;
    check(name, bus.ReadData, exp);
  endtask

  task automatic push(input logic [7:0] b);
    drive(1'b1, TXA, {24'd0, b});
    tick();
  endtask

  initial begin
    reset = 1'b1;
    bus.tx_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    model_reset();
    repeat (3) tick();
    reset = 1'b0;

    look(TMR, 32'd0, "reset_timer");
    check("reset_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("reset_err", 32'(bus.err), 32'd0);
    repeat (10) tick();
    look(TMR, 32'd10, "timer_10");

    drive(1'b1, TMR, 32'hFFFF_FFFE); tick();
    look(TMR, 32'hFFFF_FFFE, "timer_load");
    tick(); look(TMR, 32'hFFFF_FFFF, "timer_max");
    tick(); look(TMR, 32'h0000_0000, "timer_wrap");

    drive(1'b1, 32'h10, 32'hDEAD_BEEF); tick();
    look(32'h10, 32'hDEAD_BEEF, "ram_rd_0x10");
    look(32'h13, 32'hDEAD_BEEF, "ram_rd_0x13");
    drive(1'b1, 32'hFC, 32'hA5A5_A5A5); tick();
    look(32'hFC, 32'hA5A5_A5A5, "ram_last_word");

    drive(1'b1, 32'h100, 32'h1); tick();
    check("err_at_0x100", 32'(bus.err), 32'd1);
    look(32'h100, 32'd0, "rd_0x100");
    drive(1'b1, CTL, 32'h2); tick();
    check("err_cleared", 32'(bus.err), 32'd0);

    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    look(TXA, 32'h104, "status_full");
    push(8'h55);
    look(TXA, 32'h504, "status_overflow");
    check("head_after_drop", 32'(bus.tx_data), 32'h11);
    drive(1'b1, CTL, 32'h1); tick();
    look(TXA, 32'h104, "status_ovf_clr");

    bus.tx_ready = 1'b1;
    check("drain_0", 32'(bus.tx_data), 32'h11);
    tick(); check("drain_1", 32'(bus.tx_data), 32'h22);
    tick(); check("drain_2", 32'(bus.tx_data), 32'h33);
    tick(); check("drain_3", 32'(bus.tx_data), 32'h44);
    tick(); check("drain_empty", 32'(bus.tx_valid), 32'd0);
    look(TXA, 32'h200, "status_empty");

    bus.tx_ready = 1'b0;
    push(8'hA1); push(8'hA2);
    bus.tx_ready = 1'b1;
    push(8'h66);
    bus.tx_ready = 1'b0;
    look(TXA, 32'h002, "pushpop_count");
    check("pushpop_head", 32'(bus.tx_data), 32'hA2);
    push(8'h77); push(8'h88);
    look(TXA, 32'h104, "refill_full");
    bus.tx_ready = 1'b1;
    push(8'h99);
    bus.tx_ready = 1'b0;
    look(TXA, 32'h403, "full_pushpop");
    check("full_pushpop_head", 32'(bus.tx_data), 32'h66);
    bus.tx_ready = 1'b1;
    drive(1'b0, TXA, 32'd0);
    tick(); check("order_77", 32'(bus.tx_data), 32'h77);
    tick(); tick();
    check("order_empty", 32'(bus.tx_valid), 32'd0);

    drive(1'b1, 32'h4000_0000, 32'hCAFE_F00D); tick();
    look(32'h4000_0000, 32'd0, "unmapped_rd");
    check("unmapped_err", 32'(bus.err), 32'd1);
    look(32'h10, 32'hDEAD_BEEF, "ram_untouched");

    bus.tx_ready = 1'b0;
    push(8'hB1); push(8'hB2); push(8'hB3);
    bus.tx_ready = 1'b1;
    drive(1'b0, TMR, 32'd0);
    tick();
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_timer", bus.ReadData, 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    look(TMR, 32'd1, "timer_after_rst");
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
